// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, write-request type and helpers for the write-back arbiter
package wb_arbiter_pkg;

   localparam int REG_ADDR_W   = 5;
   localparam int XLEN_DEFAULT = 64;

   // One register-file write request as buffered for the secondary path
   typedef struct packed {
      logic [REG_ADDR_W-1:0]   addr;
      logic [XLEN_DEFAULT-1:0] data;
   } wb_req_t;

   // Writes to x0 are architecturally discarded
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
      return addr == '0;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with registered occupancy count; storage is not reset
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 69
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Full/empty are judged on the registered count, so a fresh entry cannot be popped in its push cycle
   assign w_push  = push_i && (r_count != FULL);
   assign w_pop   = pop_i && (r_count != '0);
   assign data_o  = r_mem[r_rd_ptr];
   assign count_o = r_count;

   // Entry storage, written on push only
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_count  <= (w_push && !w_pop) ? r_count + 1'b1 :
                     (!w_push && w_pop) ? r_count - 1'b1 : r_count;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges in-order primary and buffered secondary results onto one register-file write port
// Optional statistics counters are built when WB_ARBITER_STATS_EN is defined.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = XLEN_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  a_valid_i,
   input  logic [REG_ADDR_W-1:0] a_addr_i,
   input  logic [XLEN-1:0]       a_data_i,
   output logic                  stall_o,
   input  logic                  b_valid_i,
   input  logic [REG_ADDR_W-1:0] b_addr_i,
   input  logic [XLEN-1:0]       b_data_i,
   output logic                  b_ready_o,
   output logic                  write_en_o,
   output logic [REG_ADDR_W-1:0] write_addr_o,
   output logic [XLEN-1:0]       write_data_o
`ifdef WB_ARBITER_STATS_EN
   ,
   output logic [31:0]           stall_cnt_o,
   output logic [31:0]           b_drop_cnt_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [CW-1:0]         w_count;
   logic                  w_full;
   logic                  w_b_acc;
   logic                  w_push;
   logic                  w_grant_a;
   logic                  w_pop;
   logic [REG_ADDR_W-1:0] w_head_addr;
   logic [XLEN-1:0]       w_head_data;
   logic                  r_write_en;
   logic [REG_ADDR_W-1:0] r_write_addr;
   logic [XLEN-1:0]       r_write_data;

   // A full buffer both refuses the secondary and forces the head out ahead of the primary
   assign w_full    = w_count == FULL;
   assign stall_o   = w_full;
   assign b_ready_o = !w_full;
   assign w_b_acc   = b_valid_i && b_ready_o;
   assign w_push    = w_b_acc && !is_x0(b_addr_i);
   assign w_grant_a = a_valid_i && !stall_o;
   assign w_pop     = !w_grant_a && (w_count != '0);

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REG_ADDR_W + XLEN)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .data_i  ({b_addr_i, b_data_i}),
      .pop_i   (w_pop),
      .data_o  ({w_head_addr, w_head_data}),
      .count_o (w_count)
   );

   // Registered write port; address/data only move on a grant so they hold otherwise
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_write_en   <= 1'b0;
         r_write_addr <= '0;
         r_write_data <= '0;
      end else begin
         r_write_en <= w_grant_a ? !is_x0(a_addr_i) : w_pop;
         if (w_grant_a || w_pop) begin
            r_write_addr <= w_grant_a ? a_addr_i : w_head_addr;
            r_write_data <= w_grant_a ? a_data_i : w_head_data;
         end
      end
   end

   assign write_en_o   = r_write_en;
   assign write_addr_o = r_write_addr;
   assign write_data_o = r_write_data;

`ifdef WB_ARBITER_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_b_drop_cnt;

   // Saturating counts of stalled cycles and of handshaken x0 secondaries that were dropped
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt  <= '0;
         r_b_drop_cnt <= '0;
      end else begin
         if (stall_o && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_b_acc && is_x0(b_addr_i) && r_b_drop_cnt != '1) r_b_drop_cnt <= r_b_drop_cnt + 1'b1;
      end
   end

   assign stall_cnt_o  = r_stall_cnt;
   assign b_drop_cnt_o = r_b_drop_cnt;
`else
   // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and model-checked random tests for wb_arbiter
module tb_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        a_valid_i;
   logic [4:0]  a_addr_i;
   logic [63:0] a_data_i;
   logic        stall_o;
   logic        b_valid_i;
   logic [4:0]  b_addr_i;
   logic [63:0] b_data_i;
   logic        b_ready_o;
   logic        write_en_o;
   logic [4:0]  write_addr_o;
   logic [63:0] write_data_o;
`ifdef WB_ARBITER_STATS_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] b_drop_cnt_o;
`endif

   int n_checks = 0;
   int n_errors = 0;

   wb_arbiter #(.FIFO_DEPTH(4), .XLEN(64)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .a_valid_i    (a_valid_i),
      .a_addr_i     (a_addr_i),
      .a_data_i     (a_data_i),
      .stall_o      (stall_o),
      .b_valid_i    (b_valid_i),
      .b_addr_i     (b_addr_i),
      .b_data_i     (b_data_i),
      .b_ready_o    (b_ready_o),
      .write_en_o   (write_en_o),
      .write_addr_o (write_addr_o),
      .write_data_o (write_data_o)
`ifdef WB_ARBITER_STATS_EN
      ,
      .stall_cnt_o  (stall_cnt_o),
      .b_drop_cnt_o (b_drop_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock; inputs change and outputs are observed 1 time unit after the edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      a_valid_i = 1'b0; a_addr_i = '0; a_data_i = '0;
      b_valid_i = 1'b0; b_addr_i = '0; b_data_i = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_i = 1'b1;
      tick(); tick();
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL reset_we got=%b exp=0", write_en_o); end
      n_checks++; if (write_addr_o !== 5'd0) begin n_errors++; $display("FAIL reset_addr got=%0d exp=0", write_addr_o); end
      n_checks++; if (write_data_o !== 64'd0) begin n_errors++; $display("FAIL reset_data got=%h exp=0", write_data_o); end
      n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
      n_checks++; if (b_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_bready got=%b exp=1", b_ready_o); end
`ifdef WB_ARBITER_STATS_EN
      n_checks++; if (stall_cnt_o !== 32'd0) begin n_errors++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cnt_o); end
`endif
      rst_i = 1'b0;
   endtask

   task automatic test_primary();
      a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 64'hDEAD;
      n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL prim_stall got=%b exp=0", stall_o); end
      tick();
      a_valid_i = 1'b0;
      n_checks++; if (write_en_o !== 1'b1) begin n_errors++; $display("FAIL prim_we got=%b exp=1", write_en_o); end
      n_checks++; if (write_addr_o !== 5'd5) begin n_errors++; $display("FAIL prim_addr got=%0d exp=5", write_addr_o); end
      n_checks++; if (write_data_o !== 64'hDEAD) begin n_errors++; $display("FAIL prim_data got=%h exp=dead", write_data_o); end
      tick();
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL prim_idle_we got=%b exp=0", write_en_o); end
      n_checks++; if (write_addr_o !== 5'd5) begin n_errors++; $display("FAIL prim_hold_addr got=%0d exp=5", write_addr_o); end
   endtask

   task automatic test_secondary();
      b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 64'd1;
      tick();
      b_valid_i = 1'b0;
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL sec_early_we got=%b exp=0", write_en_o); end
      tick();
      n_checks++; if (write_en_o !== 1'b1) begin n_errors++; $display("FAIL sec_we got=%b exp=1", write_en_o); end
      n_checks++; if (write_addr_o !== 5'd7) begin n_errors++; $display("FAIL sec_addr got=%0d exp=7", write_addr_o); end
      n_checks++; if (write_data_o !== 64'd1) begin n_errors++; $display("FAIL sec_data got=%h exp=1", write_data_o); end
      tick();
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL sec_once_we got=%b exp=0", write_en_o); end
   endtask

   task automatic test_x0();
      b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 64'h55;
      n_checks++; if (b_ready_o !== 1'b1) begin n_errors++; $display("FAIL x0_bready got=%b exp=1", b_ready_o); end
      tick();
      b_valid_i = 1'b0;
      tick();
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL x0_b_we1 got=%b exp=0", write_en_o); end
      tick();
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL x0_b_we2 got=%b exp=0", write_en_o); end
`ifdef WB_ARBITER_STATS_EN
      n_checks++; if (b_drop_cnt_o !== 32'd1) begin n_errors++; $display("FAIL x0_dropcnt got=%0d exp=1", b_drop_cnt_o); end
`endif
      a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 64'h77;
      tick();
      a_valid_i = 1'b0;
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL x0_a_we got=%b exp=0", write_en_o); end
   endtask

   // Fill with A granted every cycle, then drain the FIFO in order once A goes idle
   task automatic test_stall_drain();
      for (int i = 0; i < 4; i++) begin
         a_valid_i = 1'b1; a_addr_i = 5'(20 + i); a_data_i = 64'(200 + i);
         b_valid_i = 1'b1; b_addr_i = 5'(1 + i); b_data_i = 64'(100 + i);
         tick();
         n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'(20 + i)) begin n_errors++; $display("FAIL fill_a%0d got=%b/%0d exp=1/%0d", i, write_en_o, write_addr_o, 20 + i); end
      end
      idle();
      n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL full_stall got=%b exp=1", stall_o); end
      n_checks++; if (b_ready_o !== 1'b0) begin n_errors++; $display("FAIL full_bready got=%b exp=0", b_ready_o); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'(1 + i) || write_data_o !== 64'(100 + i)) begin n_errors++; $display("FAIL drain%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, write_en_o, write_addr_o, write_data_o, 1 + i, 100 + i); end
         if (i == 0) begin
            n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL unstall got=%b exp=0", stall_o); end
         end
      end
      a_valid_i = 1'b1; a_addr_i = 5'd24; a_data_i = 64'd224;
      tick();
      a_valid_i = 1'b0;
      n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'd24) begin n_errors++; $display("FAIL a_resume got=%b/%0d exp=1/24", write_en_o, write_addr_o); end
   endtask

   // A held during a stall: one head pop, then A wins again and the rest drain later
   task automatic test_stall_priority();
      for (int i = 0; i < 4; i++) begin
         a_valid_i = 1'b1; a_addr_i = 5'(30 + i); a_data_i = 64'(300 + i);
         b_valid_i = 1'b1; b_addr_i = 5'(11 + i); b_data_i = 64'(110 + i);
         tick();
      end
      b_valid_i = 1'b0;
      a_addr_i = 5'd16; a_data_i = 64'd316;
      tick();
      n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'd11) begin n_errors++; $display("FAIL prio_pop got=%b/%0d exp=1/11", write_en_o, write_addr_o); end
      tick();
      n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'd16 || write_data_o !== 64'd316) begin n_errors++; $display("FAIL prio_a got=%b/%0d/%0d exp=1/16/316", write_en_o, write_addr_o, write_data_o); end
      a_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (write_en_o !== 1'b1 || write_addr_o !== 5'(12 + i)) begin n_errors++; $display("FAIL prio_drain%0d got=%b/%0d exp=1/%0d", i, write_en_o, write_addr_o, 12 + i); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         a_valid_i = 1'b1; a_addr_i = 5'(40 + i); a_data_i = 64'(400 + i);
         b_valid_i = 1'b1; b_addr_i = 5'(1 + i); b_data_i = 64'(900 + i);
         tick();
      end
      idle();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL rmid_we got=%b exp=0", write_en_o); end
      n_checks++; if (stall_o !== 1'b0 || b_ready_o !== 1'b1) begin n_errors++; $display("FAIL rmid_count got=stall%b/ready%b exp=0/1", stall_o, b_ready_o); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (write_en_o !== 1'b0) begin n_errors++; $display("FAIL rmid_leak%0d got=%b addr=%0d exp=0", i, write_en_o, write_addr_o); end
      end
   endtask

   // Random traffic against a queue-based reference of the arbitration rules
   task automatic test_random();
      logic [68:0] q[$];
      logic [68:0] head;
      logic        a_pend = 1'b0;
      logic        exp_we, exp_full;
      logic [4:0]  exp_addr;
      logic [63:0] exp_data;
      for (int c = 0; c < 600; c++) begin
         if (!a_pend) begin
            a_valid_i = ($urandom_range(0, 99) < 60);
            a_addr_i  = 5'($urandom_range(0, 31));
            a_data_i  = {$urandom, $urandom};
         end
         b_valid_i = ($urandom_range(0, 99) < 45);
         b_addr_i  = 5'($urandom_range(0, 7));
         b_data_i  = {$urandom, $urandom};
         exp_full = (q.size() == 4);
         n_checks++; if (stall_o !== exp_full || b_ready_o !== !exp_full) begin n_errors++; $display("FAIL rnd_flags c=%0d got=stall%b/ready%b exp=%b/%b", c, stall_o, b_ready_o, exp_full, !exp_full); end
         exp_we = 1'b0; exp_addr = '0; exp_data = '0;
         if (a_valid_i && !exp_full) begin
            exp_we = (a_addr_i != 0); exp_addr = a_addr_i; exp_data = a_data_i;
         end else if (q.size() > 0) begin
            head = q.pop_front();
            exp_we = 1'b1; exp_addr = head[68:64]; exp_data = head[63:0];
         end
         if (b_valid_i && !exp_full && b_addr_i != 0) q.push_back({b_addr_i, b_data_i});
         a_pend = a_valid_i && exp_full;
         tick();
         n_checks++; if (write_en_o !== exp_we || (exp_we && (write_addr_o !== exp_addr || write_data_o !== exp_data))) begin n_errors++; $display("FAIL rnd_write c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, write_en_o, write_addr_o, write_data_o, exp_we, exp_addr, exp_data); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_primary();
      test_secondary();
      test_x0();
      test_stall_drain();
      test_stall_priority();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
